// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control front end.
// The enum encoding is visible on the debug state port, so it is fixed explicitly.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int KEY_SS  = 0;
   localparam int KEY_CLR = 1;

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, hold-time debounce and a one-cycle
// registered press pulse on each accepted high-to-low transition of the key.
module key_debounce
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic          stable_reg;
   logic          stable_d_reg;
   logic          press_reg;
   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg    <= 1'b1;
         sync2_reg    <= 1'b1;
         stable_reg   <= 1'b1;
         stable_d_reg <= 1'b1;
         press_reg    <= 1'b0;
         count_reg    <= '0;
      end else begin
         sync1_reg    <= key_n;
         sync2_reg    <= sync1_reg;
         stable_d_reg <= stable_reg;
         // Registered one cycle after the flip, so a press reaches the FSM with fixed latency
         press_reg    <= stable_d_reg & ~stable_reg;
         if (sync2_reg == stable_reg) begin
            count_reg <= '0;
         end else if (count_reg == CW'(DEBOUNCE - 1)) begin
            stable_reg <= ~stable_reg;
            count_reg  <= '0;
         end else begin
            count_reg <= count_reg + CW'(1);
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: debounced keys, IDLE/RUN/PAUSE FSM and the 1 Hz
// prescaler that emits the tick and clear pulses for the seconds counter.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int FREQ     = 50_000_000,
   parameter int DEBOUNCE = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_n,
   output logic       tick,
   output logic       clr,
   output logic       running,
   output logic [1:0] state
);

   localparam int CNT_W = $clog2(FREQ);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FREQ - 1);

   logic [1:0]       press;
   state_t           state_reg;
   state_t           state_next;
   logic             clr_reg;
   logic             clr_next;
   logic [CNT_W-1:0] cnt_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_key
         key_debounce #(
            .DEBOUNCE(DEBOUNCE)
         ) u_key (
            .clk  (clk),
            .rst  (rst),
            .key_n(key_n[gi]),
            .press(press[gi])
         );
      end
   endgenerate

   // Start/stop is tested first everywhere, so it wins over a same-cycle clear
   always_comb begin
      state_next = state_reg;
      clr_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (press[KEY_SS]) begin
               state_next = RUN;
            end else if (press[KEY_CLR]) begin
               clr_next = 1'b1;
            end
         end
         RUN: begin
            if (press[KEY_SS]) begin
               state_next = PAUSE;
            end
         end
         PAUSE: begin
            if (press[KEY_SS]) begin
               state_next = RUN;
            end else if (press[KEY_CLR]) begin
               state_next = IDLE;
               clr_next   = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         clr_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         clr_reg   <= clr_next;
         // PAUSE keeps the phase so a resume continues the current second
         if (state_reg == IDLE || clr_next) begin
            cnt_reg <= '0;
         end else if (state_reg == RUN) begin
            cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + CNT_W'(1);
         end
      end
   end

   assign tick    = (state_reg == RUN) && (cnt_reg == CNT_MAX);
   assign clr     = clr_reg;
   assign running = (state_reg == RUN);
   assign state   = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with FREQ=10, DEBOUNCE=4: every cycle is
// compared with a behavioural model; hand sequences and a vector table cover corners.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   localparam int FREQ = 10;
   localparam int DEB  = 4;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] key_n = 2'b11;
   logic       tick;
   logic       clr;
   logic       running;
   logic [1:0] state;

   stopwatch_ctrl #(
      .FREQ    (FREQ),
      .DEBOUNCE(DEB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key_n),
      .tick   (tick),
      .clr    (clr),
      .running(running),
      .state  (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: key levels, elapsed run phase and stopwatch mode
   bit [1:0] m_s1, m_s2, m_stable, m_flip, m_press;
   int       m_len [2];
   int       m_mode  = M_IDLE;
   int       m_phase = 0;
   bit       m_clr   = 1'b0;

   typedef struct {
      logic       r;
      logic [1:0] kn;
      int         cycles;
      int         exp_state;
      logic       exp_running;
   } vec_t;

   vec_t vecs [17];

   int rise, trans, ntick, nclr, first_tick;
   int tpos [3];
   logic prev;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A key level is accepted after it has differed from the accepted level for
   // DEB synchronized samples; the FSM acts on a press two edges after acceptance.
   task automatic model_edge(input logic [1:0] kn, input logic r);
      bit [1:0] ev;
      bit [1:0] flip_now;
      int       next_mode;
      bit       clr_now;
      if (r) begin
         m_s1 = 2'b11; m_s2 = 2'b11; m_stable = 2'b11;
         m_flip = 2'b00; m_press = 2'b00;
         m_len[0] = 0; m_len[1] = 0;
         m_mode = M_IDLE; m_phase = 0; m_clr = 1'b0;
         return;
      end
      ev       = m_press;
      m_press  = m_flip;
      flip_now = 2'b00;
      for (int k = 0; k < 2; k++) begin
         if (m_s2[k] != m_stable[k]) begin
            m_len[k]++;
            if (m_len[k] == DEB) begin
               m_stable[k] = ~m_stable[k];
               m_len[k]    = 0;
               flip_now[k] = ~m_stable[k];
            end
         end else begin
            m_len[k] = 0;
         end
      end
      m_flip = flip_now;
      m_s2   = m_s1;
      m_s1   = kn;
      next_mode = m_mode;
      clr_now   = 1'b0;
      if (ev[KEY_SS]) begin
         next_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end else if (ev[KEY_CLR] && m_mode != M_RUN) begin
         next_mode = M_IDLE;
         clr_now   = 1'b1;
      end
      if (clr_now || m_mode == M_IDLE) m_phase = 0;
      else if (m_mode == M_RUN) m_phase = (m_phase + 1) % FREQ;
      m_mode = next_mode;
      m_clr  = clr_now;
   endtask

   task automatic step();
      logic [1:0] kn;
      logic       r;
      kn = key_n;
      r  = rst;
      @(posedge clk);
      #1;
      model_edge(kn, r);
      check("model_tick", tick, (m_mode == M_RUN && m_phase == FREQ - 1) ? 1 : 0);
      check("model_clr", clr, m_clr);
      check("model_running", running, (m_mode == M_RUN) ? 1 : 0);
      check("model_state", state, m_mode);
   endtask

   task automatic hold(input logic [1:0] kn, input int n);
      key_n = kn;
      repeat (n) step();
   endtask

   // Press with key pattern kn for 10 cycles, release for len-10; record events.
   // Index of the cycle where running rises counts as cycle 1 for tick positions.
   task automatic press_seq(input logic [1:0] kn, input int len);
      rise = -1; trans = 0; ntick = 0; nclr = 0; first_tick = -1;
      prev = running;
      key_n = kn;
      for (int i = 0; i < len; i++) begin
         if (i == 10) key_n = 2'b11;
         step();
         if (running != prev) trans++;
         if (running && !prev) rise = i;
         prev = running;
         if (clr) begin
            nclr++;
            check("clr_state_idle", state, M_IDLE);
            check("clr_cnt_zero", int'(dut.cnt_reg), 0);
         end
         if (tick) begin
            if (ntick < 3 && rise >= 0) tpos[ntick] = i - rise + 1;
            if (first_tick < 0 && rise >= 0) first_tick = i - rise + 1;
            ntick++;
         end
      end
   endtask

   task automatic wait_phase(input int ph);
      for (int g = 0; g < 2 * FREQ && m_phase != ph; g++) step();
      check("phase_sync_cnt", int'(dut.cnt_reg), ph);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 2'b10, 30, M_RUN,   1'b1};
      vecs[1]  = '{1'b0, 2'b11,  8, M_RUN,   1'b1};
      vecs[2]  = '{1'b0, 2'b01,  8, M_RUN,   1'b1};
      vecs[3]  = '{1'b0, 2'b11,  8, M_RUN,   1'b1};
      vecs[4]  = '{1'b0, 2'b10,  8, M_PAUSE, 1'b0};
      vecs[5]  = '{1'b0, 2'b11,  8, M_PAUSE, 1'b0};
      vecs[6]  = '{1'b0, 2'b10,  8, M_RUN,   1'b1};
      vecs[7]  = '{1'b0, 2'b11,  8, M_RUN,   1'b1};
      vecs[8]  = '{1'b0, 2'b10,  8, M_PAUSE, 1'b0};
      vecs[9]  = '{1'b0, 2'b11,  8, M_PAUSE, 1'b0};
      vecs[10] = '{1'b0, 2'b01,  8, M_IDLE,  1'b0};
      vecs[11] = '{1'b0, 2'b11,  8, M_IDLE,  1'b0};
      vecs[12] = '{1'b0, 2'b01,  8, M_IDLE,  1'b0};
      vecs[13] = '{1'b0, 2'b11,  8, M_IDLE,  1'b0};
      vecs[14] = '{1'b0, 2'b10,  8, M_RUN,   1'b1};
      vecs[15] = '{1'b0, 2'b11,  5, M_RUN,   1'b1};
      vecs[16] = '{1'b1, 2'b11,  1, M_IDLE,  1'b0};

      // Reset
      rst = 1'b1;
      hold(2'b11, 3);
      check("reset_tick", tick, 0);
      check("reset_clr", clr, 0);
      check("reset_running", running, 0);
      check("reset_state", state, 0);
      rst = 1'b0;
      $display("reset: state=%0d running=%0d", state, running);

      // Bounce shorter than the debounce window
      hold(2'b10, 2); hold(2'b11, 1); hold(2'b10, 3); hold(2'b11, 10);
      check("bounce_state", state, M_IDLE);
      $display("bounce: state=%0d", state);

      // Start press latency and tick cadence from IDLE
      press_seq(2'b10, 42);
      check("start_latency", rise, 7);
      check("start_transitions", trans, 1);
      check("run_tick_count", ntick, 3);
      check("run_tick1_pos", tpos[0], 10);
      check("run_tick2_pos", tpos[1], 20);
      check("run_tick3_pos", tpos[2], 30);
      $display("start: rise=%0d ticks=%0d at %0d/%0d/%0d", rise, ntick, tpos[0], tpos[1], tpos[2]);

      // Pause acted on while cnt=4, then 50 idle cycles, then resume
      wait_phase(7);
      press_seq(2'b10, 18);
      check("pause_state", state, M_PAUSE);
      check("pause_cnt_held", int'(dut.cnt_reg), 5);
      ntick = 0;
      key_n = 2'b11;
      for (int i = 0; i < 50; i++) begin
         step();
         if (tick) ntick++;
      end
      check("paused_no_tick", ntick, 0);
      press_seq(2'b10, 20);
      check("resume_first_tick", first_tick, 5);
      $display("pause/resume: first tick after resume at %0d", first_tick);

      // Clear ignored in RUN
      press_seq(2'b01, 18);
      check("run_clear_no_clr", nclr, 0);
      check("run_clear_ticks_continue", (ntick > 0) ? 1 : 0, 1);
      check("run_clear_state", state, M_RUN);
      // Clear honoured in PAUSE, then a fresh start
      press_seq(2'b10, 18);
      check("pause2_state", state, M_PAUSE);
      press_seq(2'b01, 18);
      check("pause_clear_clr_count", nclr, 1);
      check("pause_clear_state", state, M_IDLE);
      press_seq(2'b10, 20);
      check("restart_first_tick", first_tick, 10);
      $display("clear: clr pulses=%0d restart first tick at %0d", nclr, first_tick);

      // Simultaneous presses in PAUSE, then reset mid-run at cnt=7
      press_seq(2'b10, 18);
      check("pause3_state", state, M_PAUSE);
      press_seq(2'b00, 18);
      check("both_keys_no_clr", nclr, 0);
      check("both_keys_state", state, M_RUN);
      wait_phase(7);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", state, M_IDLE);
      check("midrst_cnt", int'(dut.cnt_reg), 0);
      check("midrst_tick", tick, 0);
      check("midrst_clr", clr, 0);
      ntick = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick) ntick++;
      end
      check("midrst_no_tick", ntick, 0);
      $display("simultaneous/reset: state=%0d ticks after reset=%0d", state, ntick);

      // Vector table
      for (int v = 0; v < 17; v++) begin
         rst = vecs[v].r;
         hold(vecs[v].kn, vecs[v].cycles);
         rst = 1'b0;
         check("vec_state", state, vecs[v].exp_state);
         check("vec_running", running, vecs[v].exp_running);
         $display("vec %0d: rst=%0b key_n=%b cycles=%0d state=%0d running=%0b",
                  v, vecs[v].r, vecs[v].kn, vecs[v].cycles, state, running);
      end

      // Random key activity against the model
      for (int s = 0; s < 2500; s++) begin
         int len;
         len   = $urandom_range(1, 12);
         key_n = 2'($urandom_range(0, 3));
         rst   = ($urandom_range(0, 199) == 0);
         step();
         rst = 1'b0;
         repeat (len - 1) step();
      end
      $display("random: done, state=%0d", state);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control front end for the 60-second seven-segment counter. Turns two raw, bouncing push buttons into clean start/stop and clear commands, runs a three-state stopwatch FSM, and produces the one-cycle 1 Hz advance pulse and clear pulse consumed by the seconds counter directly downstream. Everything above the counter's digit logic lives here; the counter itself only counts `tick` and obeys `clr`.

## Interface
- `FREQ`, default 50_000_000: clock cycles per `tick` period (1 s at 50 MHz).
- `DEBOUNCE`, default 1_000_000: cycles a synchronized key level must hold before it is accepted (20 ms at 50 MHz).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset. The top level derives it from the board reset; the downstream counter's `n_rst` is its inverse.
- `key_n`  in  2  raw asynchronous push buttons, active-low. Bit 0 is start/stop; bit 1 is clear.
- `tick`  out  1  one-cycle advance pulse for the seconds counter.
- `clr`  out  1  one-cycle pulse that zeroes the downstream counter.
- `running`  out  1  high while in RUN (LED).
- `state`  out  2  current FSM state, debug only.

## Operation
- Synchronizer: per key, a 2-flop chain. Flops reset to 1 (released).
- Debounce, per key:
  - Keep a `stable` level, reset 1, and a counter of width `$clog2(DEBOUNCE+1)`.
  - While the synchronized level equals `stable`, the counter is 0.
  - While it differs, the counter increments. On the cycle the counter reaches `DEBOUNCE-1`, `stable` flips and the counter clears.
  - A press event is a registered one-cycle pulse on a `stable` 1->0 flip. A release produces no event.
- FSM states (package enum): IDLE=0, RUN=1, PAUSE=2. Reset state is IDLE.
  - IDLE + start/stop press -> RUN.
  - RUN + start/stop press -> PAUSE.
  - PAUSE + start/stop press -> RUN.
  - PAUSE + clear press -> IDLE, with `clr` high for that one cycle.
  - IDLE + clear press -> IDLE, with `clr` pulsed.
  - RUN + clear press: ignored, no `clr`.
  - Simultaneous presses in one cycle: start/stop wins and clear is dropped.
  - Encoding 3 is unreachable; it recovers to IDLE.
- Prescaler `cnt`, width `$clog2(FREQ)`, reset 0:
  - In RUN, counts 0..FREQ-1 and wraps to 0.
  - In PAUSE, holds its value, so phase is preserved across pause and resume.
  - Forced to 0 in IDLE and on any `clr`.
- `tick` = (state==RUN) && (cnt==FREQ-1), decoded from registers only. There is no combinational path from `key_n`.
- `running` = (state==RUN).

## Timing
- Reset values: `tick`=0, `clr`=0, `running`=0, `state`=IDLE, `cnt`=0, `stable`=1, all debounce counters 0.
- Key latency: `running` or `clr` changes exactly 2 + DEBOUNCE + 1 cycles after the first rising edge that samples the key low, provided the key stays low throughout.
- Glitches shorter than DEBOUNCE synchronized cycles produce no event.
- First `tick` comes FREQ cycles after `running` rises from IDLE, then every FREQ cycles while running.
- After a resume, the first `tick` comes (FREQ-1-cnt_at_pause) cycles after `running` rises.
- `tick` and `clr` are never high in the same cycle.
- `rst` asserted mid-operation: IDLE on the next edge, `cnt` set to 0, no `tick` and no `clr` pulse. The downstream counter is reset by its own `n_rst`.
- A key held down is one event only. Re-arming requires a debounced release.

## Structure
- Package `stopwatch_pkg`:
  - `typedef enum logic [1:0] state_t` with IDLE, RUN, PAUSE.
  - Key index constants KEY_SS=0 and KEY_CLR=1.
- Sub-module `key_debounce`, instantiated twice: synchronizer, debounce counter and press-pulse register, with `DEBOUNCE` as its parameter.
- The top holds the FSM and the prescaler.

## Test plan
Run all scenarios with FREQ=10 and DEBOUNCE=4.
- Reset: hold `rst` 3 cycles with keys released -> `tick`=`clr`=`running`=0, `state`=0.
- Bounce: drive `key_n[0]` low 2 cycles, high 1 cycle, low 3 cycles, then release -> no state change. Then hold it low 10 cycles -> `running` rises exactly 7 cycles after the first low sample, with exactly one transition.
- Run ticks: stay in RUN 35 cycles -> `tick` pulses at cycles 10, 20 and 30 after `running` rises, each 1 cycle wide.
- Pause and resume: pause when `cnt`=4, wait 50 cycles -> no ticks while paused. Resume -> next `tick` 5 cycles after `running` rises.
- Clear:
  - Clear press in RUN -> no `clr`, ticks continue.
  - Clear press in PAUSE -> `clr` high 1 cycle, `state`=IDLE, `cnt`=0.
  - Next start -> first `tick` after 10 cycles.
- Simultaneous presses and reset: both keys pressed in PAUSE -> RUN with no `clr`. `rst` pulsed in RUN with `cnt`=7 -> IDLE, no `tick` over the following 20 cycles.
